// File: rtl/meco_cmd_pkg.sv
// Shared definitions for the command sequencer.
// Holds the opcode values, the instruction word field positions, the error code base,
// the one-hot state encoding and a helper that formats the error word written back to RAM.
package meco_cmd_pkg;

  // Opcodes (instruction bits [14:12]); values 4..7 are illegal.
  localparam logic [2:0] OpNop     = 3'd0;
  localparam logic [2:0] OpProgram = 3'd1;
  localparam logic [2:0] OpRead    = 3'd2;
  localparam logic [2:0] OpClear   = 3'd3;

  // Instruction word layout: [15] valid, [14:12] opcode, [11:8] nargs, [7:0] pin index.
  localparam int unsigned InstrValidBit = 15;
  localparam int unsigned OpcodeLsb     = 12;
  localparam int unsigned OpcodeW       = 3;
  localparam int unsigned NargsLsb      = 8;
  localparam int unsigned NargsW        = 4;
  localparam int unsigned PinLsb        = 0;
  localparam int unsigned PinW          = 8;

  localparam logic [15:0] ErrCodeBase = 16'hE000;

  // One-hot state encoding.
  typedef enum logic [7:0] {
    StIdle   = 8'b0000_0001,
    StFetch  = 8'b0000_0010,
    StDecode = 8'b0000_0100,
    StArgs   = 8'b0000_1000,
    StIssue  = 8'b0001_0000,
    StRdpin  = 8'b0010_0000,
    StErr    = 8'b0100_0000,
    StAck    = 8'b1000_0000
  } state_e;

  function automatic logic [15:0] err_code(input logic [2:0] opcode, input logic [7:0] pin);
    return ErrCodeBase | {5'b0, opcode, pin};
  endfunction

endpackage

// File: rtl/meco_ram_reader.sv
// RAM read sequencer shared by instruction fetch and argument fetch.
// While req_i is high the address is held for 1+RAM_LAT cycles; rd_valid_o pulses in the
// last of those cycles, when rd_data_o carries the word for addr_i. The counter restarts
// after each pulse so back-to-back reads need no gap.
// Ports: clk_i, rst_ni (async active-low), req_i, addr_i, ram_data_i (RAM read data),
//        rd_addr_o (address to RAM), rd_valid_o (data-valid pulse), rd_data_o (read word).
module meco_ram_reader #(
  parameter int unsigned ADDR_W  = 21,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned CntW = $clog2(RAM_LAT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign rd_addr_o  = addr_i;
  assign rd_valid_o = req_i && (cnt_q == CntW'(RAM_LAT));
  assign rd_data_o  = ram_data_i;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || rd_valid_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/meco_cmd_sequencer.sv
// Multi-cycle command processor between the shared dual-port RAM and the pin controller bank.
// Polls the instruction word, decodes it, fetches argument words, offers a configuration to
// the pin bank, writes READ_PIN results / error codes back and clears the instruction word
// as the acknowledge.
// Ports: clk, reset (async active-low); RAM port ram_addr/ram_data_in/ram_data_out/ram_wr/
//        ram_en; config handshake cfg_valid/cfg_ready/cfg_pin/cfg_nargs/cfg_data;
//        pins_clear pulse; pin_in levels; busy status; err pulse on a rejected instruction.
module meco_cmd_sequencer
  import meco_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_PINS    = 16,
  parameter int unsigned MAX_ARGS    = 4,
  parameter int unsigned RAM_LAT     = 1,
  parameter int unsigned INSTR_ADDR  = 'h2,
  parameter int unsigned ARG_BASE    = 'h3,
  parameter int unsigned RESULT_ADDR = 'h10
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          ram_addr,
  input  logic [DATA_W-1:0]          ram_data_in,
  output logic [DATA_W-1:0]          ram_data_out,
  output logic                       ram_wr,
  output logic                       ram_en,
  output logic                       cfg_valid,
  input  logic                       cfg_ready,
  output logic [7:0]                 cfg_pin,
  output logic [3:0]                 cfg_nargs,
  output logic [MAX_ARGS*DATA_W-1:0] cfg_data,
  output logic                       pins_clear,
  input  logic [NUM_PINS-1:0]        pin_in,
  output logic                       busy,
  output logic                       err
);

  state_e                             state_q, state_d;
  logic [DATA_W-1:0]                  instr_q, instr_d;
  logic [MAX_ARGS-1:0][DATA_W-1:0]    args_q, args_d;
  logic [3:0]                         arg_idx_q, arg_idx_d;

  logic        instr_valid;
  logic [2:0]  opcode;
  logic [3:0]  nargs;
  logic [7:0]  pin_idx;
  logic        bad_instr;
  logic        pin_level;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr_req, rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  assign instr_valid = instr_q[InstrValidBit];
  assign opcode      = instr_q[OpcodeLsb +: OpcodeW];
  assign nargs       = instr_q[NargsLsb +: NargsW];
  assign pin_idx     = instr_q[PinLsb +: PinW];

  assign cfg_pin   = pin_idx;
  assign cfg_nargs = nargs;
  assign cfg_data  = args_q;

  always_comb begin
    bad_instr = 1'b0;
    case (opcode)
      OpNop, OpClear: bad_instr = 1'b0;
      OpProgram: bad_instr = (32'(pin_idx) >= NUM_PINS) || (nargs == 4'd0) ||
                             (32'(nargs) > MAX_ARGS);
      OpRead:    bad_instr = 32'(pin_idx) >= NUM_PINS;
      default:   bad_instr = 1'b1;
    endcase
  end

  // Pin index is range-checked in DECODE, so only in-range indices reach RDPIN.
  always_comb begin
    pin_level = 1'b0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (pin_idx == 8'(i)) pin_level = pin_in[i];
    end
  end

  assign rd_req      = (state_q == StFetch) || (state_q == StArgs);
  assign rd_addr_req = (state_q == StFetch) ? ADDR_W'(INSTR_ADDR)
                                            : ADDR_W'(ARG_BASE) + ADDR_W'(arg_idx_q);

  meco_ram_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RAM_LAT(RAM_LAT)
  ) u_ram_reader (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (rd_req),
    .addr_i    (rd_addr_req),
    .ram_data_i(ram_data_in),
    .rd_addr_o (rd_addr),
    .rd_valid_o(rd_valid),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    args_d    = args_q;
    arg_idx_d = arg_idx_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (rd_valid) begin
          instr_d = rd_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!instr_valid) begin
          state_d = StIdle;
        end else if (bad_instr) begin
          state_d = StErr;
        end else if (opcode == OpProgram) begin
          args_d    = '0;
          arg_idx_d = '0;
          state_d   = StArgs;
        end else if (opcode == OpRead) begin
          state_d = StRdpin;
        end else begin
          state_d = StAck;
        end
      end
      StArgs: begin
        if (rd_valid) begin
          for (int k = 0; k < MAX_ARGS; k++) begin
            if (arg_idx_q == 4'(k)) args_d[k] = rd_data;
          end
          if (arg_idx_q == nargs - 4'd1) begin
            arg_idx_d = '0;
            state_d   = StIssue;
          end else begin
            arg_idx_d = arg_idx_q + 4'd1;
          end
        end
      end
      StIssue: begin
        if (cfg_ready) state_d = StAck;
      end
      StRdpin, StErr: state_d = StAck;
      StAck:          state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  // Outputs decode directly from the registered one-hot state, so reset clears them at once.
  always_comb begin
    ram_en       = 1'b1;
    ram_wr       = 1'b0;
    ram_addr     = rd_addr;
    ram_data_out = '0;
    cfg_valid    = 1'b0;
    pins_clear   = 1'b0;
    err          = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      StIdle: begin
        ram_en   = 1'b0;
        busy     = 1'b0;
        ram_addr = '0;
      end
      StFetch, StArgs: begin
      end
      StDecode: pins_clear = instr_valid && !bad_instr && (opcode == OpClear);
      StIssue:  cfg_valid = 1'b1;
      StRdpin: begin
        ram_wr       = 1'b1;
        ram_addr     = ADDR_W'(RESULT_ADDR);
        ram_data_out = DATA_W'(pin_level);
      end
      StErr: begin
        err          = 1'b1;
        ram_wr       = 1'b1;
        ram_addr     = ADDR_W'(RESULT_ADDR);
        ram_data_out = err_code(opcode, pin_idx);
      end
      StAck: begin
        ram_wr   = 1'b1;
        ram_addr = ADDR_W'(INSTR_ADDR);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      args_q    <= '0;
      arg_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      args_q    <= args_d;
      arg_idx_q <= arg_idx_d;
    end
  end

endmodule

// File: tb/tb_meco_cmd_sequencer.sv
// Directed bench for meco_cmd_sequencer with a behavioural RAM (read latency 1).
module tb_meco_cmd_sequencer;

  localparam int unsigned ADDR_W   = 21;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_PINS = 16;
  localparam int unsigned MAX_ARGS = 4;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [ADDR_W-1:0]          ram_addr;
  logic [DATA_W-1:0]          ram_data_in = '0;
  logic [DATA_W-1:0]          ram_data_out;
  logic                       ram_wr;
  logic                       ram_en;
  logic                       cfg_valid;
  logic                       cfg_ready = 1'b1;
  logic [7:0]                 cfg_pin;
  logic [3:0]                 cfg_nargs;
  logic [MAX_ARGS*DATA_W-1:0] cfg_data;
  logic                       pins_clear;
  logic [NUM_PINS-1:0]        pin_in = '0;
  logic                       busy;
  logic                       err;

  logic [15:0] mem [0:31];
  logic        host_we = 1'b0;
  logic [4:0]  host_addr = '0;
  logic [15:0] host_data = '0;

  int acc_cnt = 0, ack_wr_cnt = 0, wr_cnt = 0, err_cnt = 0;
  int clr_cnt = 0, valid_cnt = 0, fetch_cnt = 0;
  int errors = 0, checks = 0;

  meco_cmd_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .ram_wr      (ram_wr),
    .ram_en      (ram_en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pin     (cfg_pin),
    .cfg_nargs   (cfg_nargs),
    .cfg_data    (cfg_data),
    .pins_clear  (pins_clear),
    .pin_in      (pin_in),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  // RAM model plus event counters.
  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_data;
    else if (ram_en && ram_wr && ram_addr < 21'd32) mem[ram_addr[4:0]] <= ram_data_out;
    if (ram_en && !ram_wr) begin
      ram_data_in <= (ram_addr < 21'd32) ? mem[ram_addr[4:0]] : 16'hDEAD;
    end
    if (cfg_valid && cfg_ready) acc_cnt <= acc_cnt + 1;
    if (ram_en && ram_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_addr == 21'd2) ack_wr_cnt <= ack_wr_cnt + 1;
    end
    if (ram_en && !ram_wr && ram_addr == 21'd2) fetch_cnt <= fetch_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (pins_clear) clr_cnt <= clr_cnt + 1;
    if (cfg_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Counts posedges until cfg_valid is seen at a negedge; bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cfg_valid) break;
    end
    chk("cfg_valid_seen", 64'(cfg_valid), 64'd1);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int a0, k0, e0, v0, c0, w0, f0;
    logic [63:0] d0;
    logic stable;

    host_write(5'd2, 16'h9203);
    host_write(5'd3, 16'hAAAA);
    host_write(5'd4, 16'h5555);
    host_write(5'd5, 16'h1234);
    host_write(5'd6, 16'h5678);
    host_write(5'd16, 16'h0000);

    // Reset state
    chk("reset_ctrl", 64'({busy, ram_en, ram_wr, cfg_valid, pins_clear, err}), 64'd0);
    chk("reset_addr", 64'(ram_addr), 64'd0);
    chk("reset_cfg_data", cfg_data, 64'd0);

    // PROGRAM_PIN, 2 args, ready tied high
    @(negedge clk);
    reset = 1'b1;
    wait_valid(cyc);
    chk("prog_latency", 64'(cyc - 1), 64'd7);
    chk("prog_pin", 64'(cfg_pin), 64'd3);
    chk("prog_nargs", 64'(cfg_nargs), 64'd2);
    chk("prog_data", cfg_data, 64'h0000_0000_5555_AAAA);
    run(10);
    chk("prog_ack_mem", 64'(mem[2]), 64'd0);
    chk("prog_accepts", 64'(acc_cnt), 64'd1);
    chk("prog_ack_writes", 64'(ack_wr_cnt), 64'd1);

    // Same instruction, back-pressure for 10 cycles
    cfg_ready = 1'b0;
    a0 = acc_cnt;
    k0 = ack_wr_cnt;
    host_write(5'd2, 16'h9203);
    wait_valid(cyc);
    d0 = cfg_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!cfg_valid || cfg_data !== d0 || cfg_pin !== 8'd3 || cfg_nargs !== 4'd2) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    chk("hold_data", d0, 64'h0000_0000_5555_AAAA);
    chk("hold_no_accept", 64'(acc_cnt - a0), 64'd0);
    cfg_ready = 1'b1;
    run(10);
    chk("hold_one_accept", 64'(acc_cnt - a0), 64'd1);
    chk("hold_one_ack", 64'(ack_wr_cnt - k0), 64'd1);
    chk("hold_valid_dropped", 64'(cfg_valid), 64'd0);
    chk("hold_ack_mem", 64'(mem[2]), 64'd0);

    // PROGRAM_PIN, 4 args, pin 15 (upper legal bounds)
    host_write(5'd2, 16'h940F);
    wait_valid(cyc);
    chk("max_pin", 64'(cfg_pin), 64'h0F);
    chk("max_nargs", 64'(cfg_nargs), 64'd4);
    chk("max_data", cfg_data, 64'h5678_1234_5555_AAAA);
    run(10);
    // PROGRAM_PIN, 1 arg: unused slots must be cleared
    host_write(5'd2, 16'h9103);
    wait_valid(cyc);
    chk("one_arg_data", cfg_data, 64'h0000_0000_0000_AAAA);
    run(10);
    chk("one_arg_ack_mem", 64'(mem[2]), 64'd0);

    // READ_PIN pin 5 high, then low with all other pins high
    pin_in = 16'h0020;
    host_write(5'd16, 16'hFFFF);
    e0 = err_cnt;
    host_write(5'd2, 16'hA005);
    run(20);
    chk("read_hi_result", 64'(mem[16]), 64'h0001);
    chk("read_hi_ack_mem", 64'(mem[2]), 64'd0);
    chk("read_no_err", 64'(err_cnt - e0), 64'd0);
    pin_in = 16'hFFDF;
    host_write(5'd2, 16'hA005);
    run(20);
    chk("read_lo_result", 64'(mem[16]), 64'h0000);

    // Rejected instructions
    v0 = valid_cnt;
    e0 = err_cnt;
    host_write(5'd2, 16'h9514);
    run(20);
    chk("err_nargs_pulse", 64'(err_cnt - e0), 64'd1);
    chk("err_nargs_code", 64'(mem[16]), 64'hE114);
    chk("err_nargs_no_cfg", 64'(valid_cnt - v0), 64'd0);
    chk("err_nargs_ack_mem", 64'(mem[2]), 64'd0);
    host_write(5'd2, 16'h9003);
    run(20);
    chk("err_zero_nargs_code", 64'(mem[16]), 64'hE103);
    host_write(5'd2, 16'hC003);
    run(20);
    chk("err_opcode_code", 64'(mem[16]), 64'hE403);
    host_write(5'd2, 16'hA010);
    run(20);
    chk("err_pin_range_code", 64'(mem[16]), 64'hE210);
    chk("err_total_pulses", 64'(err_cnt - e0), 64'd4);

    // CLEAR_PINS and NOP
    c0 = clr_cnt;
    host_write(5'd2, 16'hB000);
    run(20);
    chk("clear_pulse_count", 64'(clr_cnt - c0), 64'd1);
    chk("clear_ack_mem", 64'(mem[2]), 64'd0);
    e0 = err_cnt;
    host_write(5'd2, 16'h8000);
    run(20);
    chk("nop_ack_mem", 64'(mem[2]), 64'd0);
    chk("nop_no_err", 64'(err_cnt - e0), 64'd0);

    // valid=0: polling without writes
    host_write(5'd2, 16'h0203);
    w0 = wr_cnt;
    f0 = fetch_cnt;
    run(30);
    chk("invalid_no_writes", 64'(wr_cnt - w0), 64'd0);
    chk("invalid_mem_kept", 64'(mem[2]), 64'h0203);
    chk("invalid_polling", 64'(fetch_cnt - f0 > 4), 64'd1);

    // Reset during ISSUE
    cfg_ready = 1'b0;
    a0 = acc_cnt;
    host_write(5'd2, 16'h9203);
    wait_valid(cyc);
    #2 reset = 1'b0;
    #1;
    chk("rst_issue_ctrl", 64'({busy, ram_en, ram_wr, cfg_valid, pins_clear, err}), 64'd0);
    chk("rst_issue_cfg", 64'({cfg_pin, cfg_nargs}), 64'd0);
    chk("rst_issue_data", cfg_data, 64'd0);
    chk("rst_issue_addr", 64'(ram_addr), 64'd0);
    run(3);
    chk("rst_issue_no_accept", 64'(acc_cnt - a0), 64'd0);
    chk("rst_issue_instr_kept", 64'(mem[2]), 64'h9203);
    reset = 1'b1;
    wait_valid(cyc);
    chk("rst_reissue_data", cfg_data, 64'h0000_0000_5555_AAAA);
    chk("rst_reissue_pin", 64'(cfg_pin), 64'd3);
    cfg_ready = 1'b1;
    run(10);
    chk("rst_reissue_accept", 64'(acc_cnt - a0), 64'd1);
    chk("rst_reissue_ack_mem", 64'(mem[2]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
